// File: rtl/data_mem_hs.sv
// data_mem_hs
//   Word-organised data memory behind a request/response handshake with a
//   configurable number of wait states. Handles RV32 sub-word loads/stores
//   (lb/lh/lw/lbu/lhu, sb/sh/sw) using byte enables. Misaligned, out-of-window
//   and illegal-funct3 accesses are reported through rsp_err and never touch
//   the RAM.
//
// Handshake: a request transfers on the rising edge where req_valid and
//   req_ready are both 1; a response transfers on the rising edge where
//   rsp_valid and rsp_ready are both 1. While valid is high and ready is low,
//   the source holds its payload; the block drops requests presented while
//   req_ready is low and holds the response stable until it is taken.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_funct3          RV32 load/store funct3
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           extended load data; 0 for stores and faults
//   rsp_err             access fault
//   dbg_state           current FSM state (IDLE=0, WAIT=1, RESP=2)
module data_mem_hs #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          WAIT_STATES = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Window limit kept in 33 bits so a window ending at the top of the
  // address space cannot wrap back into range.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic        err_q;

  logic        accept;
  logic        oor, mis, ill, err_now;
  logic        cur_we, cur_err;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [IW-1:0] cur_idx;
  logic [3:0]  be;
  logic [31:0] lane_data;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign req_ready = rst_n && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // Fault classification of the request on the input pins (used at accept).
  always_comb begin
    oor = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr} > LAST_ADDR);
    mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we) ill = (req_funct3 > 3'b010);
    else        ill = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    err_now = oor || mis || ill;
  end

  // In IDLE the request pins are the live access (store write, or the
  // zero-wait load read); afterwards the latched copy is.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we   = req_we;
      cur_f3   = req_funct3;
      cur_addr = req_addr;
      cur_err  = err_now;
    end else begin
      cur_we   = we_q;
      cur_f3   = f3_q;
      cur_addr = addr_q;
      cur_err  = err_q;
    end
    cur_idx = IW'((cur_addr - BASE_ADDR) >> 2);
  end

  // Store byte enables and replicated lane data.
  always_comb begin
    be        = 4'b1111;
    lane_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err_now) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  // Load lane select and extension.
  assign rd_word = mem[cur_idx];

  always_comb begin
    case (cur_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            addr_q   <= req_addr;
            err_q    <= err_now;
            wait_cnt <= 4'd0;
            if (NO_WAIT) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= cur_err;
              rsp_rdata <= (cur_err || cur_we) ? 32'd0 : load_val;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= 4'd0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_rdata <= (cur_err || cur_we) ? 32'd0 : load_val;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs
//   Three instances (WAIT_STATES = 1, 0, 3) of data_mem_hs driven from one
//   directed/random sequence. Expected results come from a byte-addressed
//   reference memory and a rule-level fault classifier.
module tb_data_mem_hs;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 16384;
  localparam int          NI    = 3;

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [2:0]  req_funct3[NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic [1:0]  dbg_state [NI];

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_b [longint];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_hs #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3),
      .INIT_FILE  ("")
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic longint key(input int k, input logic [31:0] a);
    return (longint'(k) << 32) + longint'(a);
  endfunction

  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    longint lo = longint'(BASE);
    longint hi = longint'(BASE) + 4 * DEPTH;
    bit bad;
    bad = (longint'(a) < lo) || (longint'(a) >= hi);
    if (we) bad = bad || (f3 > 3'd2);
    else    bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (!bad) bad = (int'(a % 32'(sz(f3))) != 0);
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int n = sz(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[key(k, a + 32'(i))];
    if (!f3[2] && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic ref_store(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < sz(f3); i++) ref_b[key(k, a + 32'(i))] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k with latency/data/fault checks.
  task automatic access(input int k, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int n;
    bit exp_e;
    logic [31:0] exp_d;
    exp_e = ref_err(we, f3, a);
    exp_d = (exp_e || we) ? 32'd0 : ref_load(k, f3, a);
    @(negedge clk);
    chk({tag, "/req_ready"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
    req_addr[k] = a; req_wdata[k] = wd;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    if (we && !exp_e) ref_store(k, f3, a, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[k] && n < 40);
    chk({tag, "/latency"}, 32'(n), 32'(ws_of(k) + 1));
    chk({tag, "/rdata"}, rsp_rdata[k], exp_d);
    chk({tag, "/err"}, 32'(rsp_err[k]), 32'(exp_e));
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk({tag, "/idle_ready"}, 32'(req_ready[k]), 32'd1);
    chk({tag, "/idle_valid"}, 32'(rsp_valid[k]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_funct3[k] = 3'd0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d/req_ready", k), 32'(req_ready[k]), 32'd0);
      chk($sformatf("rst%0d/rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("rst%0d/rsp_rdata", k), rsp_rdata[k], 32'd0);
      chk($sformatf("rst%0d/rsp_err", k), 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("rel%0d/req_ready", k), 32'(req_ready[k]), 32'd1);

    // Word store/load, one wait state
    access(0, 1'b1, 3'b010, 32'h1001_0010, 32'hDEAD_BEEF, "t1_sw");
    access(0, 1'b0, 3'b010, 32'h1001_0010, 32'd0, "t1_lw");

    // Byte store over a known word, sub-word loads
    access(0, 1'b1, 3'b010, 32'h1001_0010, 32'h1122_3344, "t2_sw");
    access(0, 1'b1, 3'b000, 32'h1001_0013, 32'h0000_005A, "t2_sb");
    access(0, 1'b0, 3'b000, 32'h1001_0013, 32'd0, "t2_lb");
    access(0, 1'b0, 3'b100, 32'h1001_0013, 32'd0, "t2_lbu");
    access(0, 1'b0, 3'b101, 32'h1001_0012, 32'd0, "t2_lhu");
    access(0, 1'b0, 3'b010, 32'h1001_0010, 32'd0, "t2_lw");
    access(0, 1'b1, 3'b001, 32'h1001_0016, 32'h0000_8001, "t2_sh");
    access(0, 1'b0, 3'b001, 32'h1001_0016, 32'd0, "t2_lh_neg");

    // Faulting accesses leave memory untouched
    access(0, 1'b1, 3'b010, 32'h1001_0000, 32'h0BAD_F00D, "t3_init");
    access(0, 1'b0, 3'b001, 32'h1001_0001, 32'd0, "t3_lh_mis");
    access(0, 1'b1, 3'b010, 32'h1001_0002, 32'hFFFF_FFFF, "t3_sw_mis");
    access(0, 1'b0, 3'b010, 32'h1000_FFFC, 32'd0, "t3_lw_below");
    access(0, 1'b0, 3'b010, 32'h1002_0000, 32'd0, "t3_lw_above");
    access(0, 1'b0, 3'b011, 32'h1001_0010, 32'd0, "t3_ld_ill");
    access(0, 1'b1, 3'b100, 32'h1001_0000, 32'h1234_5678, "t3_st_ill");
    access(0, 1'b0, 3'b010, 32'h1001_0000, 32'd0, "t3_readback");
    access(0, 1'b0, 3'b010, 32'h1001_0010, 32'd0, "t3_readback2");

    // Back-pressure on the response
    access(0, 1'b1, 3'b010, 32'h1001_0040, 32'hCAFE_F00D, "t4_sw");
    access(0, 1'b1, 3'b010, 32'h1001_0044, 32'h0000_0000, "t4_sw2");
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h1001_0040;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    r = 0;
    do begin
      @(negedge clk);
      r++;
    end while (!rsp_valid[0] && r < 40);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d/rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("t4_hold%0d/rdata", i), rsp_rdata[0], 32'hCAFE_F00D);
      chk($sformatf("t4_hold%0d/err", i), 32'(rsp_err[0]), 32'd0);
      chk($sformatf("t4_hold%0d/req_ready", i), 32'(req_ready[0]), 32'd0);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
      req_addr[0] = 32'h1001_0044; req_wdata[0] = 32'h1234_5678;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("t4_release/req_ready", 32'(req_ready[0]), 32'd1);
    chk("t4_release/rsp_valid", 32'(rsp_valid[0]), 32'd0);
    access(0, 1'b0, 3'b010, 32'h1001_0044, 32'd0, "t4_ignored");

    // Reset during WAIT of an accepted store (instance with 3 wait states)
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'b001;
    req_addr[2] = 32'h1001_0020; req_wdata[2] = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    ref_store(2, 3'b001, 32'h1001_0020, 32'h0000_BEEF);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("t5_rst/rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("t5_rst/req_ready", 32'(req_ready[2]), 32'd0);
    chk("t5_rst/rsp_rdata", rsp_rdata[2], 32'd0);
    chk("t5_rst/rsp_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("t5_rel/rsp_valid", 32'(rsp_valid[2]), 32'd0);
    access(2, 1'b0, 3'b101, 32'h1001_0020, 32'd0, "t5_lhu");

    // Zero and three wait states, window edges
    for (int k = 1; k < NI; k++) begin
      access(k, 1'b1, 3'b010, 32'h1001_0010, 32'hDEAD_BEEF, $sformatf("t6_%0d_sw", k));
      access(k, 1'b0, 3'b010, 32'h1001_0010, 32'd0, $sformatf("t6_%0d_lw", k));
      access(k, 1'b1, 3'b010, 32'h1001_FFFC, 32'h600D_CAFE, $sformatf("t6_%0d_sw_last", k));
      access(k, 1'b0, 3'b010, 32'h1001_FFFC, 32'd0, $sformatf("t6_%0d_lw_last", k));
      access(k, 1'b0, 3'b000, 32'h1001_FFFF, 32'd0, $sformatf("t6_%0d_lb_last", k));
      access(k, 1'b0, 3'b010, 32'h1002_0000, 32'd0, $sformatf("t6_%0d_lw_past", k));
    end

    // Random traffic against the reference model
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 32; w++)
        access(k, 1'b1, 3'b010, 32'h1001_0100 + 32'(4 * w), $urandom, $sformatf("rnd%0d_fill", k));
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      a = BASE - 32'($urandom_range(1, 8));
        else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
        else             a = 32'h1001_0100 + 32'($urandom_range(0, 127));
        access(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
